conbus_rr: RTL

Parametrised Wishbone shared-bus interconnect: N masters, M slaves, one transfer in flight at a time. Successor to the fixed 7-master/6-slave bus. It adds:
- round-robin arbitration with bus hold;
- a per-slave address table;
- routing of ack/err from the selected slave only;
- a bus-error response for unmapped addresses;
- a watchdog timeout.

It sits between the LM32 instruction/data ports (plus DMA masters) and the SoC peripherals.

---
 rtl/conbus_pkg.sv | 18 +
 rtl/conbus_rr_arb.sv | 75 +++++++
 rtl/conbus_rr.sv | 133 +++++++++++++
 3 files changed

// File: rtl/conbus_pkg.sv
// Shared Wishbone widths, cycle-type codes and arbiter state encoding.
package conbus_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int WB_CTI_W = 3;

    localparam logic [WB_CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [WB_CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [WB_CTI_W-1:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/conbus_rr_arb.sv
// Round-robin arbiter with bus hold. The owner keeps the grant for as long as
// its request stays high. A release always passes through one idle cycle
// before the next grant.
module conbus_rr_arb
    import conbus_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic [IDX_W-1:0] owner,
    output arb_state_t       state
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick;
    logic             found;

    // State register; after reset last_q points at the top master so master 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            own_q   <= '0;
            last_q  <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end
    end

    // Next state: scan upward from last_q+1 with wrap while idle, release when the owner drops req.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        pick    = last_q;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last_q) + k) % N]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(last_q) + k) % N);
            end
        end
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_OWN;
                    own_d   = pick;
                    last_d  = pick;
                end
            end
            ARB_OWN: begin
                if (!req[own_q]) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs: one-hot grant only while owned.
    always_comb begin
        gnt   = '0;
        busy  = (state_q == ARB_OWN);
        owner = own_q;
        state = state_q;
        if (busy) gnt[own_q] = 1'b1;
    end

endmodule

// File: rtl/conbus_rr.sv
// Shared-bus Wishbone interconnect: N masters, M slaves, one transfer at a time.
// Round-robin arbitration with hold, table-based slave decode, error response
// for unmapped addresses and an unanswered-strobe watchdog.
module conbus_rr
    import conbus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 6,
    parameter int S_ADDR_W  = 3,
    parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDR = {3'h5, 3'h4, 3'h3, 3'h2, 3'h1, 3'h0},
    parameter int TIMEOUT   = 255
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [N_MASTERS*WB_ADR_W-1:0] m_adr_i,
    input  logic [N_MASTERS*WB_DAT_W-1:0] m_dat_i,
    input  logic [N_MASTERS*WB_CTI_W-1:0] m_cti_i,
    input  logic [N_MASTERS*WB_SEL_W-1:0] m_sel_i,
    input  logic [N_MASTERS-1:0]          m_we_i,
    input  logic [N_MASTERS-1:0]          m_cyc_i,
    input  logic [N_MASTERS-1:0]          m_stb_i,
    output logic [WB_DAT_W-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]          m_ack_o,
    output logic [N_MASTERS-1:0]          m_err_o,
    output logic [WB_ADR_W-1:0]           s_adr_o,
    output logic [WB_DAT_W-1:0]           s_dat_o,
    output logic [WB_CTI_W-1:0]           s_cti_o,
    output logic [WB_SEL_W-1:0]           s_sel_o,
    output logic                          s_we_o,
    output logic [N_SLAVES-1:0]           s_cyc_o,
    output logic [N_SLAVES-1:0]           s_stb_o,
    input  logic [N_SLAVES*WB_DAT_W-1:0]  s_dat_i,
    input  logic [N_SLAVES-1:0]           s_ack_i,
    input  logic [N_SLAVES-1:0]           s_err_i,
    output arb_state_t                    arb_state
);

    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [N_MASTERS-1:0] gnt;
    logic                 busy;
    logic [IDX_W-1:0]     owner;
    logic                 own_cyc, own_stb;
    logic                 hit;
    logic [SEL_W-1:0]     sel;
    logic                 sl_ack, sl_err;
    logic                 pending, unmapped, timeout_hit;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;

    conbus_rr_arb #(.N(N_MASTERS)) u_arb (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .req   (m_cyc_i),
        .gnt   (gnt),
        .busy  (busy),
        .owner (owner),
        .state (arb_state)
    );

    // Owner mux onto the shared slave-side bus; everything reads 0 with no owner.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_cti_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (busy) begin
            s_adr_o = m_adr_i[int'(owner)*WB_ADR_W +: WB_ADR_W];
            s_dat_o = m_dat_i[int'(owner)*WB_DAT_W +: WB_DAT_W];
            s_cti_o = m_cti_i[int'(owner)*WB_CTI_W +: WB_CTI_W];
            s_sel_o = m_sel_i[int'(owner)*WB_SEL_W +: WB_SEL_W];
            s_we_o  = m_we_i[owner];
            own_cyc = m_cyc_i[owner];
            own_stb = m_stb_i[owner];
        end
    end

    // Address decode: scanning downward leaves the lowest matching table entry selected.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int j = N_SLAVES - 1; j >= 0; j--) begin
            if (busy && (s_adr_o[WB_ADR_W-1 -: S_ADDR_W] == S_ADDR[j*S_ADDR_W +: S_ADDR_W])) begin
                hit = 1'b1;
                sel = SEL_W'(j);
            end
        end
    end

    // Slave gating and response routing: only the decoded slave is seen, only the owner is answered.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        sl_ack  = 1'b0;
        sl_err  = 1'b0;
        if (hit) begin
            s_cyc_o[sel] = own_cyc;
            s_stb_o[sel] = own_stb;
            m_dat_o      = s_dat_i[int'(sel)*WB_DAT_W +: WB_DAT_W];
            sl_ack       = s_ack_i[sel];
            sl_err       = s_err_i[sel];
        end
        m_ack_o = gnt & {N_MASTERS{sl_ack & ~sl_err}};
        m_err_o = gnt & {N_MASTERS{sl_err | err_q}};
    end

    // Error sources: a strobe still waiting for an answer, an unmapped strobe, or the watchdog limit.
    always_comb begin
        pending     = own_stb & ~(sl_ack | sl_err | err_q);
        unmapped    = own_stb & ~hit & ~err_q;
        timeout_hit = (TIMEOUT != 0) && pending && (cnt_q == CNT_LAST);
    end

    // Watchdog counter and one-cycle generated error; any answer or a dropped strobe restarts it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= unmapped | timeout_hit;
            if ((TIMEOUT != 0) && pending && !timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
            else                                           cnt_q <= '0;
        end
    end

endmodule
